operand_issuer: RTL
===================

// Module: operand_issuer
// PURPOSE
//  Transmit side of the fault-tolerant 3-bit adder channel. Accepts operation requests and
//  drives A/B with odd parity (PAR) and a one-hot control word (C). Samples the X result
//  and its two-rail error code, retries flagged operations, and returns a checked response.
//  Sits between the test/host sequencer and the combinational adder.
// PARAMETERS
//  SETTLE     2  cycles A/B/PAR/C are held stable before X/XC/XE are sampled (>=1)
//  MAX_RETRY  3  re-issues allowed after an error-flagged sample (0 = no retry)
// PORTS
//  clk          in   1  clock; all state on rising edge
//  rst          in   1  reset, asynchronous, active-high
//  req_valid    in   1  request offered
//  req_ready    out  1  issuer can accept a request (IDLE only)
//  req_a        in   3  operand A
//  req_b        in   3  operand B
//  req_op       in   2  0=ADD (C=001), 1=SUB A-B (C=010), 2=RSUB B-A (C=100), 3=illegal
//  inj_par      in   1  captured with request: transmit inverted PAR (fault injection)
//  A0..A2,B0..B2 out 1 each  registered operands to adder
//  PAR          out  1  registered parity; A0^A1^A2^B0^B1^B2^PAR = 1 unless injected
//  C0,C1,C2     out  1 each  registered one-hot control
//  X0..X2,XC    in   1 each  adder sum/carry
//  XE0,XE1      in   1 each  two-rail error code; (XE1,XE0)=(1,0) = good, any other = error
//  rsp_valid    out  1  response available
//  rsp_ready    in   1  response consumed when rsp_valid & rsp_ready
//  rsp_sum      out  3  sampled {X2,X1,X0}
//  rsp_carry    out  1  sampled XC
//  rsp_err      out  1  final sample still error-flagged after all retries
//  rsp_mismatch out  1  final sample code good but {XC,X} != locally computed expected
//  rsp_retries  out  2  re-issues used (saturates at MAX_RETRY)
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; A=B=000, PAR=1, C=001; req_ready=1 after reset release;
//   rsp_valid=0, rsp_* = 0; retry and settle counters 0. Reset mid-operation discards it.
//  States: IDLE -> DRIVE -> SAMPLE -> (DRIVE on retry | RESP) ; RESP -> IDLE.
//  IDLE: req_ready=1. On req_valid: capture a,b,op,inj_par; load A/B/PAR/C next edge; ->DRIVE.
//   req_op=3: no drive; go straight to RESP with rsp_err=1, rsp_sum=0, rsp_carry=0.
//  DRIVE: hold outputs, count SETTLE cycles, then ->SAMPLE. req_ready=0 in all non-IDLE states.
//  SAMPLE (1 cycle): register X, XC, XE. Good code -> RESP. Error code and retries<MAX_RETRY:
//   retries+1, ->DRIVE (same operands, settle counter restarts). Else -> RESP, rsp_err=1.
//  Expected value: ADD {c,s}=a+b; SUB a+~b+1; RSUB ~a+b+1; 4-bit result, top bit = carry.
//   rsp_mismatch=1 only when final code good and sample != expected; never with rsp_err=1.
//  RESP: rsp_valid=1, outputs stable until rsp_ready; handshake -> IDLE, rsp_valid=0 next cycle.
//   Request accepted no earlier than the cycle after the response handshake.
//  Outputs A/B/PAR/C keep last values in IDLE/RESP (C always one-hot, never 000).
//  Latency good path: accept edge + SETTLE + 1 sample + 1 -> rsp_valid; each retry adds SETTLE+1.
// TESTING
//  ADD a=3,b=5, good code -> A=011,B=101,PAR=1,C=001; rsp_sum=000,rsp_carry=1,err=0,retries=0.
//  SUB a=5,b=3 -> C=010; rsp_sum=010,rsp_carry=1; RSUB a=5,b=3 -> C=100; sum=110,carry=0.
//  XE=(0,0) every sample, MAX_RETRY=3 -> 4 issues, rsp_err=1, rsp_retries=3; PAR held all along.
//  inj_par=1, adder flags error once then good -> PAR=0 on wire, rsp_retries=1, rsp_err=0.
//  Good code but forced X=111 on ADD 1+1 -> rsp_mismatch=1; req_op=3 -> rsp_err=1, C stays 001.
//  rst pulsed in DRIVE -> outputs A=B=0,PAR=1,C=001 immediately; rsp_ready held 0 in RESP
//   for 5 cycles -> rsp_* stable, req_ready=0 throughout.

Source files
------------

// File: rtl/operand_issuer.sv
// Transmit side of the fault-tolerant 3-bit adder channel.
// Accepts a request (a, b, op). Drives A/B with odd parity PAR and a one-hot control C.
// Holds them for SETTLE cycles, then samples X/XC and the two-rail code XE.
// Re-issues on a flagged code up to MAX_RETRY times, then returns a checked response.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; req_a, req_b, req_op, inj_par payload
//   A0..A2, B0..B2, PAR, C0..C2   registered operands, parity and one-hot control to adder
//   X0..X2, XC, XE0, XE1          adder sum, carry and two-rail error code
//   rsp_valid/rsp_ready           response handshake
//   rsp_sum, rsp_carry            sampled result
//   rsp_err                       final sample still flagged, or illegal op
//   rsp_mismatch                  good code but result differs from expected
//   rsp_retries                   number of re-issues used
module operand_issuer #(
  parameter int unsigned SETTLE    = 2,  // >= 1
  parameter int unsigned MAX_RETRY = 3   // must fit the 2-bit retry counter
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_a,
  input  logic [2:0] req_b,
  input  logic [1:0] req_op,
  input  logic       inj_par,
  output logic       A0,
  output logic       A1,
  output logic       A2,
  output logic       B0,
  output logic       B1,
  output logic       B2,
  output logic       PAR,
  output logic       C0,
  output logic       C1,
  output logic       C2,
  input  logic       X0,
  input  logic       X1,
  input  logic       X2,
  input  logic       XC,
  input  logic       XE0,
  input  logic       XE1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_sum,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       rsp_mismatch,
  output logic [1:0] rsp_retries
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrive  = 2'd1;
  localparam logic [1:0] StSample = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
  localparam logic [1:0] MaxRetry = 2'(MAX_RETRY);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic [2:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic            par_q, par_d;
  logic [3:0]      exp_q, exp_d;
  logic [2:0]      sum_q, sum_d;
  logic            carry_q, carry_d, err_q, err_d, mis_q, mis_d;
  logic [3:0]      exp_calc;

  // Reference result for the self-check; 4 bits, top bit is the carry.
  always_comb begin
    exp_calc = 4'd0;
    case (req_op)
      2'd0:    exp_calc = {1'b0, req_a} + {1'b0, req_b};
      2'd1:    exp_calc = {1'b0, req_a} + {1'b0, ~req_b} + 4'd1;
      2'd2:    exp_calc = {1'b0, ~req_a} + {1'b0, req_b} + 4'd1;
      default: exp_calc = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    par_d   = par_q;
    exp_d   = exp_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          retry_d = 2'd0;
          cnt_d   = '0;
          sum_d   = 3'd0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          mis_d   = 1'b0;
          if (req_op == 2'd3) begin
            // Illegal op: nothing is driven, the wires keep their last values.
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            a_d     = req_a;
            b_d     = req_b;
            par_d   = ~((^req_a) ^ (^req_b)) ^ inj_par;
            c_d     = 3'b001 << req_op;
            exp_d   = exp_calc;
            state_d = StDrive;
          end
        end
      end
      StDrive: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        sum_d   = {X2, X1, X0};
        carry_d = XC;
        cnt_d   = '0;
        if ({XE1, XE0} == 2'b10) begin
          mis_d   = ({XC, X2, X1, X0} != exp_q);
          state_d = StResp;
        end else if (retry_q < MaxRetry) begin
          retry_d = retry_q + 2'd1;
          state_d = StDrive;
        end else begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      retry_q <= 2'd0;
      a_q     <= 3'd0;
      b_q     <= 3'd0;
      c_q     <= 3'b001;
      par_q   <= 1'b1;
      exp_q   <= 4'd0;
      sum_q   <= 3'd0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      par_q   <= par_d;
      exp_q   <= exp_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign {A2, A1, A0} = a_q;
  assign {B2, B1, B0} = b_q;
  assign {C2, C1, C0} = c_q;
  assign PAR          = par_q;
  assign rsp_sum      = sum_q;
  assign rsp_carry    = carry_q;
  assign rsp_err      = err_q;
  assign rsp_mismatch = mis_q;
  assign rsp_retries  = retry_q;

endmodule
